// File: rtl/uio_bus_arbiter.sv
// Purpose : round-robin owner arbitration of the shared 8-bit uio pad bank, with a pad-released turnaround gap between owners.
// Latency : req rising before edge E0 on an idle bus gives a grant after edge E0+TURN_CYC; read data appears one cycle after its sample edge.
// Backpressure: none; req is level-held and the owner keeps the bus until it drops req or is preempted after MAX_HOLD cycles.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   ena             design enable; low forces the bus back to idle
//   req, dir        per-requester request (level) and direction (1 = drive pads)
//   wdata           write data, requester i on bits [8i+7:8i]
//   uio_in          pad input path
//   uio_out, uio_oe pad output data and output enable
//   grant           one-hot registered grant
//   rdata, rvalid   registered pad sample for a reading owner and its strobe
//   busy            high while in TURN or OWN
// Optional macro UIO_ARB_PRIORITY_EN: requester 0 wins every arbitration it
// takes part in and is never force-released by the hold limit.
module uio_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16,
  parameter int TURN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   dir,
  input  logic [NREQ*8-1:0] wdata,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD);
  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
  localparam logic [IW-1:0] OWNER_MAX = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          dir_q, dir_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] turn_q, turn_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;

  logic [NREQ-1:0] owner_oh;
  logic            own_act;
  logic            others_pending;
  logic            force_rel;
  logic            release_own;
  logic [IW-1:0]   win;
  logic            found;
  int              idx;

  assign owner_oh       = NREQ'(1) << owner_q;
  assign own_act        = (state_q == OWN);
  assign others_pending = |(req & ~owner_oh);

  // Outputs are decoded from registered state only, so an async reset
  // releases the pads immediately; uio_out is the sole combinational path.
  assign grant   = own_act ? owner_oh : '0;
  assign uio_oe  = (own_act && dir_q) ? 8'hFF : 8'h00;
  assign uio_out = (own_act && dir_q) ? wdata[owner_q*8 +: 8] : 8'h00;
  assign busy    = (state_q != IDLE);
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;

  // Winner: first set req at or after the rr pointer, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
`ifdef UIO_ARB_PRIORITY_EN
    if (req[0]) win = '0;
`endif
  end

`ifdef UIO_ARB_PRIORITY_EN
  assign force_rel = (owner_q != '0) && (hold_q == HOLD_LAST) && others_pending;
`else
  assign force_rel = (hold_q == HOLD_LAST) && others_pending;
`endif

  assign release_own = !req[owner_q] || force_rel;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    dir_d    = dir_q;
    rr_d     = rr_q;
    hold_d   = hold_q;
    turn_d   = turn_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ena && |req) begin
          owner_d = win;
          dir_d   = dir[win];
          turn_d  = '0;
          state_d = TURN;
        end
      end
      TURN: begin
        // Abort beats completion so a dropped request never sees a grant.
        if (!req[owner_q]) begin
          state_d = IDLE;
        end else if (turn_q == TURN_LAST) begin
          hold_d  = '0;
          state_d = OWN;
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end
      OWN: begin
        if (release_own) begin
          rr_d    = (owner_q == OWNER_MAX) ? '0 : owner_q + 1'b1;
          state_d = IDLE;
        end else begin
          // Saturating: a lone owner keeps the bus until someone else asks.
          if (hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;
          if (!dir_q) begin
            rdata_d  = uio_in;
            rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Disable wins over everything and freezes the arbitration history.
    if (!ena) begin
      state_d  = IDLE;
      owner_d  = owner_q;
      dir_d    = dir_q;
      rr_d     = rr_q;
      hold_d   = hold_q;
      turn_d   = turn_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      dir_q    <= 1'b0;
      rr_q     <= '0;
      hold_q   <= '0;
      turn_q   <= '0;
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      dir_q    <= dir_d;
      rr_q     <= rr_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule
